// File: rtl/mem_stage_lsu.sv
// Memory stage with load/store unit: byte-lane stores, load extraction/extension,
// req/gnt/rvalid data-memory handshake with wait states, and the MEM/WB register.
module mem_stage_lsu #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                EX_valid_i,
  input  logic [XLEN-1:0]     EX_ALU_result_i,
  input  logic [REG_AW-1:0]   EX_Rd_i,
  input  logic                EX_Reg_writeE_i,
  input  logic [1:0]          EX_Rd_source_i,
  input  logic [2:0]          EX_Mem_op_size_i,
  input  logic                EX_Mem_Write_i,
  input  logic                EX_Mem_Read_i,
  input  logic                EX_Load_sign_i,
  input  logic [XLEN-1:0]     EX_RS2_i,
  output logic                MEM_stall_o,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [XLEN-1:0]     dmem_addr_o,
  output logic [XLEN/8-1:0]   dmem_be_o,
  output logic [XLEN-1:0]     dmem_wdata_o,
  input  logic                dmem_gnt_i,
  input  logic                dmem_rvalid_i,
  input  logic [XLEN-1:0]     dmem_rdata_i,
  output logic                WB_valid_o,
  output logic [REG_AW-1:0]   WB_Rd_o,
  output logic                WB_Reg_writeE_o,
  output logic [1:0]          WB_Rd_source_o,
  output logic [XLEN-1:0]     WB_ALU_result_o,
  output logic [XLEN-1:0]     WB_Load_data_o,
  output logic                MEM_misalign_o
);

  localparam int BEW  = XLEN / 8;
  localparam int OFFW = $clog2(BEW);
  localparam int IDXW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RV} state_e;

  state_e            state_q, state_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;

  logic              wbValid_q, wbValid_d;
  logic [REG_AW-1:0] wbRd_q, wbRd_d;
  logic              wbWe_q, wbWe_d;
  logic [1:0]        wbSrc_q, wbSrc_d;
  logic [XLEN-1:0]   wbAlu_q, wbAlu_d;
  logic [XLEN-1:0]   wbLoad_q, wbLoad_d;
  logic              misalign_q, misalign_d;

  logic              memOp;
  logic              isWrite;
  logic              misaligned;
  logic [OFFW-1:0]   off;
  logic [1:0]        sizeSh;
  logic [2:0]        alignMask;
  logic [BEW-1:0]    beLanes;
  logic              reqInt;
  logic              complete;
  logic              latchLoad;
  logic              misalignEvt;
  logic              loadDone;
  logic              stallInt;
  logic [XLEN-1:0]   loadShifted;
  logic [XLEN-1:0]   loadExt;
  logic [IDXW-1:0]   topIdx;
  logic              extBit;

  assign memOp     = EX_valid_i & (EX_Mem_Read_i | EX_Mem_Write_i);
  assign isWrite   = EX_Mem_Write_i;
  assign off       = EX_ALU_result_i[OFFW-1:0];
  assign sizeSh    = EX_Mem_op_size_i[1:0];
  assign alignMask = 3'((4'd1 << sizeSh) - 4'd1);
  // Sizes above 3 and doublewords on a 32-bit datapath can never be aligned.
  assign misaligned = EX_Mem_op_size_i[2]
                    | ((XLEN == 32) && (EX_Mem_op_size_i == 3'd3))
                    | ((EX_ALU_result_i[2:0] & alignMask) != 3'd0);
  assign beLanes   = BEW'(((16'd1 << (4'd1 << sizeSh)) - 16'd1) << off);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      off_q   <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    reqInt      = 1'b0;
    complete    = 1'b0;
    latchLoad   = 1'b0;
    misalignEvt = 1'b0;
    loadDone    = 1'b0;
    case (state_q)
      IDLE: begin
        if (memOp) begin
          if (misaligned) begin
            complete    = 1'b1;
            misalignEvt = 1'b1;
          end else begin
            reqInt = 1'b1;
            if (dmem_gnt_i) begin
              if (isWrite) begin
                complete = 1'b1;
              end else begin
                latchLoad = 1'b1;
                state_d   = WAIT_RV;
              end
            end else begin
              state_d = WAIT_GNT;
            end
          end
        end
      end
      WAIT_GNT: begin
        reqInt = 1'b1;
        if (dmem_gnt_i) begin
          if (isWrite) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            latchLoad = 1'b1;
            state_d   = WAIT_RV;
          end
        end
      end
      WAIT_RV: begin
        if (dmem_rvalid_i) begin
          complete = 1'b1;
          loadDone = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign off_d  = latchLoad ? off : off_q;
  assign size_d = latchLoad ? sizeSh : size_q;
  assign sign_d = latchLoad ? EX_Load_sign_i : sign_q;

  // Extract the addressed lanes, then fill everything above the access width.
  always_comb begin
    loadShifted = dmem_rdata_i >> {off_q, 3'b000};
    topIdx      = IDXW'((32'd8 << size_q) - 32'd1);
    extBit      = sign_q & loadShifted[topIdx];
    loadExt     = loadShifted;
    for (int i = 0; i < XLEN; i++) begin
      if (i > int'(topIdx)) begin
        loadExt[i] = extBit;
      end
    end
  end

  assign stallInt = memOp & ~complete;

  always_comb begin
    wbValid_d  = EX_valid_i & ~stallInt;
    wbWe_d     = EX_valid_i & ~stallInt & EX_Reg_writeE_i & ~misalignEvt;
    wbRd_d     = EX_Rd_i;
    wbSrc_d    = EX_Rd_source_i;
    wbAlu_d    = EX_ALU_result_i;
    wbLoad_d   = loadDone ? loadExt : '0;
    misalign_d = misalignEvt;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wbValid_q  <= 1'b0;
      wbRd_q     <= '0;
      wbWe_q     <= 1'b0;
      wbSrc_q    <= '0;
      wbAlu_q    <= '0;
      wbLoad_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      wbValid_q  <= wbValid_d;
      wbRd_q     <= wbRd_d;
      wbWe_q     <= wbWe_d;
      wbSrc_q    <= wbSrc_d;
      wbAlu_q    <= wbAlu_d;
      wbLoad_q   <= wbLoad_d;
      misalign_q <= misalign_d;
    end
  end

  // Reset also masks the combinational outputs so the bus is quiet immediately.
  assign MEM_stall_o  = stallInt & rst_i;
  assign dmem_req_o   = reqInt & rst_i;
  assign dmem_we_o    = dmem_req_o & isWrite;
  assign dmem_addr_o  = dmem_req_o ? {EX_ALU_result_i[XLEN-1:OFFW], {OFFW{1'b0}}} : '0;
  assign dmem_be_o    = dmem_req_o ? beLanes : '0;
  assign dmem_wdata_o = dmem_req_o ? (EX_RS2_i << {off, 3'b000}) : '0;

  assign WB_valid_o      = wbValid_q;
  assign WB_Rd_o         = wbRd_q;
  assign WB_Reg_writeE_o = wbWe_q;
  assign WB_Rd_source_o  = wbSrc_q;
  assign WB_ALU_result_o = wbAlu_q;
  assign WB_Load_data_o  = wbLoad_q;
  assign MEM_misalign_o  = misalign_q;

endmodule
